// File: rtl/fetch_pkg.sv
// Shared types and constants for the multicycle fetch/decode sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int unsigned OPC_HI = 7;
  localparam int unsigned OPC_LO = 5;
  localparam int unsigned RS_BIT = 4;
  localparam int unsigned RT_BIT = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classifier for the instruction register.
module instr_decode
  import fetch_pkg::*;
(
  input  logic [2:0] opc,
  output logic       is_nop,
  output logic       is_lw,
  output logic       is_add,
  output logic       is_sw,
  output logic       is_hlt,
  output logic       illegal
);

  assign is_nop  = (opc == OP_NOP);
  assign is_lw   = (opc == OP_LW);
  assign is_add  = (opc == OP_ADD);
  assign is_sw   = (opc == OP_SW);
  assign is_hlt  = (opc == OP_HLT);
  assign illegal = ~(is_nop | is_lw | is_add | is_sw | is_hlt);

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle control FSM: owns the PC and IR, sequences fetch/decode/exec/mem/wb phases,
// runs the data-memory req/ack handshake and counts retired instructions.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [7:0] PC_FIRST    = 8'd1,
  parameter logic [7:0] PC_LAST     = 8'd3,
  parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] instr_in,
  input  logic       mem_ack,
  output logic [7:0] pc_addr,
  output logic [7:0] ir,
  output logic       rs_sel,
  output logic       rt_sel,
  output logic       alu_en,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_we,
  output logic       retire,
  output logic [7:0] retire_cnt,
  output logic       busy,
  output logic       halted,
  output logic [1:0] err
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] err_q, err_d;
  logic [3:0] wait_q, wait_d;
  logic       advance;

  logic is_nop, is_lw, is_add, is_sw, is_hlt, illegal;

  instr_decode u_decode (
    .opc     (ir_q[OPC_HI:OPC_LO]),
    .is_nop  (is_nop),
    .is_lw   (is_lw),
    .is_add  (is_add),
    .is_sw   (is_sw),
    .is_hlt  (is_hlt),
    .illegal (illegal)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wait_d  = wait_q;
    alu_en  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    reg_we  = 1'b0;
    retire  = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      StIdle: if (start) state_d = StFetch;
      StFetch: begin
        ir_d    = instr_in;
        state_d = StDecode;
      end
      StDecode: begin
        if (is_lw || is_sw) begin
          wait_d  = 4'd0;
          state_d = StMem;
        end else if (is_add) begin
          state_d = StExec;
        end else if (is_nop) begin
          retire  = 1'b1;
          advance = 1'b1;
        end else if (is_hlt) begin
          retire  = 1'b1;
          state_d = StHalt;
        end else if (illegal) begin
          err_d   = ERR_ILLEGAL;
          state_d = StHalt;
        end
      end
      StExec: begin
        alu_en  = 1'b1;
        state_d = StWb;
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        if (mem_ack) begin
          if (is_lw) begin
            state_d = StWb;
          end else begin
            retire  = 1'b1;
            advance = 1'b1;
          end
        end else begin
          // Ack wins over timeout when it lands in the final permitted cycle.
          wait_d = wait_q + 4'd1;
          if (wait_d == MEM_TIMEOUT) begin
            err_d   = ERR_TIMEOUT;
            state_d = StHalt;
          end
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        advance = 1'b1;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase

    if (retire) cnt_d = sat_inc8(cnt_q);
    if (advance) begin
      if (pc_q == PC_LAST) begin
        state_d = StHalt;
      end else begin
        pc_d    = pc_q + 8'd1;
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= PC_FIRST;
      ir_q    <= 8'd0;
      cnt_q   <= 8'd0;
      err_q   <= ERR_NONE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign pc_addr    = pc_q;
  assign ir         = ir_q;
  assign rs_sel     = ir_q[RS_BIT];
  assign rt_sel     = ir_q[RT_BIT];
  assign retire_cnt = cnt_q;
  assign err        = err_q;
  assign busy       = (state_q != StIdle) && (state_q != StHalt);
  assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench: an instruction-level model expands each program into an expected
// per-cycle trace (inputs and outputs), which is replayed and compared every cycle.
module tb_fetch_sequencer;

  logic       clk, rst, start, mem_ack;
  logic [7:0] instr_in, pc_addr, ir, retire_cnt;
  logic       rs_sel, rt_sel, alu_en, mem_req, mem_we, reg_we, retire, busy, halted;
  logic [1:0] err;

  logic [7:0] imem [256];
  assign instr_in = imem[pc_addr];

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instr_in   (instr_in),
    .mem_ack    (mem_ack),
    .pc_addr    (pc_addr),
    .ir         (ir),
    .rs_sel     (rs_sel),
    .rt_sel     (rt_sel),
    .alu_en     (alu_en),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .retire     (retire),
    .retire_cnt (retire_cnt),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       ack;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       alu;
    logic       req;
    logic       we;
    logic       rwe;
    logic       ret;
    logic [7:0] cnt;
    logic       busy;
    logic       halted;
    logic [1:0] err;
  } cyc_t;

  cyc_t trace[$];
  cyc_t exp_cur;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc_no = 0;

  logic [7:0] m_pc, m_ir, m_cnt;
  logic [1:0] m_err;
  bit         m_done;
  int         m_start_idx;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_addr", pc_addr, exp_cur.pc);
      chk("ir", ir, exp_cur.ir);
      chk("rs_sel", {7'd0, rs_sel}, {7'd0, exp_cur.ir[4]});
      chk("rt_sel", {7'd0, rt_sel}, {7'd0, exp_cur.ir[3]});
      chk("alu_en", {7'd0, alu_en}, {7'd0, exp_cur.alu});
      chk("mem_req", {7'd0, mem_req}, {7'd0, exp_cur.req});
      chk("mem_we", {7'd0, mem_we}, {7'd0, exp_cur.we});
      chk("reg_we", {7'd0, reg_we}, {7'd0, exp_cur.rwe});
      chk("retire", {7'd0, retire}, {7'd0, exp_cur.ret});
      chk("retire_cnt", retire_cnt, exp_cur.cnt);
      chk("busy", {7'd0, busy}, {7'd0, exp_cur.busy});
      chk("halted", {7'd0, halted}, {7'd0, exp_cur.halted});
      chk("err", {6'd0, err}, {6'd0, exp_cur.err});
    end
  end

  function automatic cyc_t base(input bit is_busy);
    cyc_t e = '0;
    e.start = ($urandom_range(0, 3) == 0);
    e.ack   = 1'($urandom_range(0, 1));
    e.pc    = m_pc;
    e.ir    = m_ir;
    e.cnt   = m_cnt;
    e.err   = m_err;
    e.busy  = is_busy;
    return e;
  endfunction

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  // Retirement of a non-halting instruction: count it, then move on or stop at the last address.
  task automatic retire_adv();
    m_cnt = sat(m_cnt);
    if (m_pc == 8'd3) m_done = 1'b1;
    else m_pc = m_pc + 8'd1;
  endtask

  function automatic int rand_delay();
    int r = $urandom_range(0, 9);
    if (r == 0) return 16;
    if (r == 1) return 15;
    if (r <= 3) return $urandom_range(7, 14);
    return $urandom_range(1, 4);
  endfunction

  function automatic logic [7:0] rand_instr();
    int r = $urandom_range(0, 11);
    logic [2:0] op;
    if (r <= 1) op = 3'b000;
    else if (r <= 4) op = 3'b001;
    else if (r <= 7) op = 3'b010;
    else if (r <= 9) op = 3'b100;
    else if (r == 10) op = 3'b111;
    else op = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b110;
    return {op, 5'($urandom)};
  endfunction

  // d_lw/d_sw: MEM cycle in which ack arrives (>15 means never); negative picks at random.
  task automatic build(input int d_lw, input int d_sw);
    cyc_t e;
    int n_idle, d;
    logic [2:0] op;
    trace.delete();
    m_pc = 8'd1; m_ir = 8'd0; m_cnt = 8'd0; m_err = 2'd0; m_done = 1'b0;
    n_idle = $urandom_range(1, 3);
    for (int i = 0; i < n_idle; i++) begin
      e = base(1'b0);
      e.start = (i == n_idle - 1);
      trace.push_back(e);
    end
    m_start_idx = n_idle - 1;
    while (!m_done) begin
      trace.push_back(base(1'b1));
      m_ir = imem[m_pc];
      op = m_ir[7:5];
      e = base(1'b1);
      case (op)
        3'b000: begin e.ret = 1'b1; trace.push_back(e); retire_adv(); end
        3'b111: begin e.ret = 1'b1; trace.push_back(e); m_cnt = sat(m_cnt); m_done = 1'b1; end
        3'b010: begin
          trace.push_back(e);
          e = base(1'b1); e.alu = 1'b1; trace.push_back(e);
          e = base(1'b1); e.rwe = 1'b1; e.ret = 1'b1; trace.push_back(e);
          retire_adv();
        end
        3'b001, 3'b100: begin
          trace.push_back(e);
          d = (op == 3'b001) ? d_lw : d_sw;
          if (d < 0) d = rand_delay();
          for (int k = 1; k <= 15; k++) begin
            e = base(1'b1);
            e.req = 1'b1;
            e.we  = (op == 3'b100);
            e.ack = (k == d);
            e.ret = (k == d) && (op == 3'b100);
            trace.push_back(e);
            if (k == d) break;
          end
          if (d > 15) begin
            m_err = 2'd2; m_done = 1'b1;
          end else if (op == 3'b001) begin
            e = base(1'b1); e.rwe = 1'b1; e.ret = 1'b1; trace.push_back(e);
            retire_adv();
          end else begin
            retire_adv();
          end
        end
        default: begin trace.push_back(e); m_err = 2'd1; m_done = 1'b1; end
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      e = base(1'b0);
      e.halted = 1'b1;
      trace.push_back(e);
    end
  endtask

  // Replay the trace; rst_at >= 0 asserts rst during that (still checked) cycle.
  task automatic run(input int rst_at);
    for (int i = 0; i < trace.size(); i++) begin
      @(posedge clk); #1;
      start   = trace[i].start;
      mem_ack = trace[i].ack;
      rst     = (i == rst_at);
      exp_cur = trace[i];
      chk_en  = 1'b1;
      cyc_no++;
      if (i == rst_at) break;
    end
    if (rst_at < 0) begin
      @(posedge clk); #1;
      rst = 1'b1; chk_en = 1'b0; start = 1'b0; mem_ack = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b0; start = 1'b0; mem_ack = 1'b1;
    cyc_no++;
    @(negedge clk);
    chk("post_rst_pc", pc_addr, 8'd1);
    chk("post_rst_cnt", retire_cnt, 8'd0);
    chk("post_rst_strobes", {2'd0, alu_en, mem_req, mem_we, reg_we, retire, busy}, 8'd0);
  endtask

  function automatic int count_req();
    int n = 0;
    foreach (trace[i]) if (trace[i].req) n++;
    return n;
  endfunction

  task automatic load_base_prog();
    foreach (imem[i]) imem[i] = 8'd0;
    imem[1] = 8'b00110000;
    imem[2] = 8'b01001000;
    imem[3] = 8'b10000001;
  endtask

  initial begin
    int s, rst_at;
    cyc_t last;
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0;
    load_base_prog();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_pc", pc_addr, 8'd1);
    chk("reset_ir", ir, 8'd0);
    chk("reset_halted", {7'd0, halted}, 8'd0);

    // Base program, immediate acks.
    build(1, 1);
    s = m_start_idx;
    chk("model_pc1", trace[s + 1].pc, 8'd1);
    chk("model_pc2", trace[s + 5].pc, 8'd2);
    chk("model_pc3", trace[s + 9].pc, 8'd3);
    chk("model_ret4", {7'd0, trace[s + 4].ret}, 8'd1);
    chk("model_ret8", {7'd0, trace[s + 8].ret}, 8'd1);
    chk("model_ret11", {7'd0, trace[s + 11].ret}, 8'd1);
    chk("model_halt12", {7'd0, trace[s + 12].halted}, 8'd1);
    last = trace[trace.size() - 1];
    chk("model_final_cnt", last.cnt, 8'd3);
    run(-1);

    // LW ack delayed to fifth MEM cycle.
    build(5, 1);
    chk("model_req_delayed", 8'(count_req()), 8'd6);
    last = trace[trace.size() - 1];
    chk("model_cnt_delayed", last.cnt, 8'd3);
    run(-1);

    // Illegal opcode at address 2.
    imem[2] = 8'b01100000;
    build(1, 1);
    last = trace[trace.size() - 1];
    chk("model_ill_err", {6'd0, last.err}, 8'd1);
    chk("model_ill_cnt", last.cnt, 8'd1);
    chk("model_ill_pc", last.pc, 8'd2);
    chk("model_ill_req", 8'(count_req()), 8'd1);
    run(-1);
    load_base_prog();

    // SW never acknowledged.
    build(1, 16);
    last = trace[trace.size() - 1];
    chk("model_to_err", {6'd0, last.err}, 8'd2);
    chk("model_to_req", 8'(count_req()), 8'd16);
    run(-1);

    // Reset in the second MEM cycle of the LW, then a clean re-run.
    build(3, 1);
    rst_at = m_start_idx + 4;
    chk("model_rst_in_mem", {7'd0, trace[rst_at].req}, 8'd1);
    run(rst_at);
    build(1, 1);
    run(-1);

    for (int iter = 0; iter < 40; iter++) begin
      for (int a = 1; a <= 3; a++) imem[a] = rand_instr();
      build(-1, -1);
      rst_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, trace.size() - 1) : -1;
      run(rst_at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multicycle control FSM that sequences the 8-bit instruction memory and a data-memory port for the small lw/add/sw datapath.
- Owns the PC and drives it onto the instruction-memory address, which reads combinationally.
- Latches the returned word into an instruction register (IR), decodes opcode IR[7:5], and issues per-phase control strobes.
- Performs a req/ack handshake with data memory, counts retired instructions, and halts at the program end or on an error.

Parameters:
- PC_FIRST, 8'd1, address of the first instruction; location 0 is unused.
- PC_LAST, 8'd3, address of the last instruction; retiring it enters HALT.
- MEM_TIMEOUT, 4'd15, maximum MEM-state cycles without mem_ack before an error halt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; leaves IDLE (ignored in any other state).
- instr_in  in  8  instruction-memory data_out, combinational from pc_addr.
- mem_ack  in  1  data-memory completion, sampled only in MEM.
- pc_addr  out  8  registered PC to instruction memory.
- ir  out  8  registered instruction register.
- rs_sel  out  1  IR[4], source/base register select.
- rt_sel  out  1  IR[3], second register select.
- alu_en  out  1  high in EXEC.
- mem_req  out  1  high in MEM.
- mem_we  out  1  high in MEM for sw.
- reg_we  out  1  high in WB.
- retire  out  1  one-cycle pulse when an instruction completes.
- retire_cnt  out  8  retired-instruction count, saturates at 255.
- busy  out  1  high in any state other than IDLE or HALT.
- halted  out  1  high in HALT.
- err  out  2  halt cause: 0 none, 1 illegal opcode, 2 memory timeout; sticky.

Behaviour:
- Opcodes (IR[7:5]):
  - 000 NOP
  - 001 LW
  - 010 ADD
  - 100 SW
  - 111 HLT
  - all others illegal
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (any state, including mid-MEM): state=IDLE, pc_addr=PC_FIRST, ir=0, retire_cnt=0, err=0, wait counter=0. All strobes are 0 in the following cycle, so mem_req drops at the reset edge.
- IDLE: start=1 -> FETCH.
- FETCH (1 cycle): pc_addr is stable; at the exiting edge ir<=instr_in -> DECODE.
- DECODE (1 cycle):
  - LW or SW -> MEM.
  - ADD -> EXEC.
  - NOP -> retire; retire point.
  - HLT -> HALT; counts as retired.
  - Illegal -> HALT with err=1; not retired.
- EXEC (1 cycle) -> WB.
- MEM: mem_req=1 each cycle. On mem_ack=1: LW -> WB; SW -> retire point. Otherwise the wait counter increments; when it equals MEM_TIMEOUT -> HALT with err=2. The wait counter clears on MEM entry.
- WB (1 cycle): reg_we=1 -> retire point.
- Retire point, in the same cycle:
  - retire=1 and retire_cnt+1 (saturating).
  - If pc_addr==PC_LAST -> HALT.
  - Else pc_addr<=pc_addr+1 (8-bit wrap) -> FETCH.
- HALT: absorbing; start is ignored; exit only by rst.
- Latency with mem_ack asserted in the first MEM cycle: NOP 2, ADD 4, LW 4, SW 3 cycles from FETCH entry to retire.
- Strobes are Moore-decoded from state plus IR; no strobe is asserted in IDLE or HALT.
- mem_ack outside MEM has no effect.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum
  - opcode constants OP_NOP/OP_LW/OP_ADD/OP_SW/OP_HLT
  - err code constants
  - field positions OPC_HI=7, OPC_LO=5, RS_BIT=4, RT_BIT=3
- One natural sub-module: instr_decode (combinational IR -> is_lw/is_add/is_sw/is_nop/is_hlt/illegal). The FSM, PC, counters and handshake stay in fetch_sequencer.

Test Plan:
- Program 1:00110000, 2:01001000, 3:10000001 with mem_ack tied high; start pulse ->
  - pc_addr sequence 1,2,3
  - retire at cycles 4, 8, 11 after start
  - reg_we for LW and ADD, mem_we only for SW
  - then halted=1, err=0, retire_cnt=3
- Same program, mem_ack delayed 5 cycles on LW -> mem_req is high exactly 5 cycles, then WB; total retire_cnt=3.
- Instruction 01100000 at address 2 -> halted=1, err=1, retire_cnt=1, pc_addr=2, mem_req never asserted for it.
- mem_ack held 0 on SW -> after 15 MEM cycles halted=1, err=2, mem_req=0 in HALT.
- rst asserted during MEM with mem_req=1 -> next cycle state IDLE, pc_addr=1, all strobes 0, retire_cnt=0; a fresh start re-runs the program correctly.
- start pulses during busy and during HALT -> no effect on pc_addr or retire_cnt.
